// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Shares one external combinational 4-bit ALU between two requesters.
// A round-robin arbiter picks one requester in IDLE. The accepted operation
// is held on registered ALU operand/opcode outputs. The ALU result and carry
// are then captured into a response channel that is tagged with the ID of the
// requester that issued the operation.
//
// FSM: IDLE -> EXEC -> RESP -> IDLE.
//  - EXEC lasts one cycle. During that cycle the ALU settles on the
//    registered operands.
//  - RESP holds the response until the consumer takes it.
//
// Configuration macro:
//   ALU_ARB_FIXED_PRIO_EN  When this macro is defined, requester 0 always
//                          wins a tie. The last-served ID is still tracked,
//                          but the arbiter ignores it.
//
// Ports:
//   clk, rst_n                       clock (rising edge), async active-low reset
//   req0_valid/ready/a/b/sel         requester 0 handshake and operation
//   req1_valid/ready/a/b/sel         requester 1 handshake and operation
//   rsp_valid/ready/id/result/carry  response channel
//   alu_a, alu_b, alu_sel            registered drive into the ALU
//   alu_result, alu_carry            combinational return from the ALU
//   busy                             high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module alu_arbiter #(
   parameter int DATA_W = 4,
   parameter int SEL_W  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic [SEL_W-1:0]  req0_sel,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   input  logic [SEL_W-1:0]  req1_sel,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic [DATA_W-1:0] rsp_result,
   output logic              rsp_carry,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [SEL_W-1:0]  alu_sel,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_carry,
   output logic              busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t              state_r;
   logic                last_r;
   logic                id_r;
   logic                busy_r;
   logic                rsp_valid_r;
   logic                rsp_id_r;
   logic [DATA_W-1:0]   rsp_result_r;
   logic                rsp_carry_r;
   logic [DATA_W-1:0]   alu_a_r;
   logic [DATA_W-1:0]   alu_b_r;
   logic [SEL_W-1:0]    alu_sel_r;

   logic                grant_s;
   logic                idle_s;
   logic                req0_ready_s;
   logic                req1_ready_s;
   logic                accept_s;

   // Arbitration: pick the winning requester from the valids and the last-served ID.
   always_comb begin
      grant_s = 1'b0;
      if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
         grant_s = 1'b0;
`else
         // On a tie, serve the requester that was not served last.
         grant_s = ~last_r;
`endif
      end else if (req1_valid) begin
         grant_s = 1'b1;
      end else begin
         grant_s = 1'b0;
      end
   end

   // The ready terms are gated by rst_n so that they read 0 while reset is held.
   assign idle_s       = (state_r == ST_IDLE);
   assign req0_ready_s = rst_n & idle_s & req0_valid & ~grant_s;
   assign req1_ready_s = rst_n & idle_s & req1_valid &  grant_s;
   assign accept_s     = req0_ready_s | req1_ready_s;

   // Main FSM: capture the operation, sample the ALU, and hold the response until it is taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         last_r       <= 1'b1;
         id_r         <= 1'b0;
         busy_r       <= 1'b0;
         rsp_valid_r  <= 1'b0;
         rsp_id_r     <= 1'b0;
         rsp_result_r <= {DATA_W{1'b0}};
         rsp_carry_r  <= 1'b0;
         alu_a_r      <= {DATA_W{1'b0}};
         alu_b_r      <= {DATA_W{1'b0}};
         alu_sel_r    <= {SEL_W{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  alu_a_r   <= grant_s ? req1_a   : req0_a;
                  alu_b_r   <= grant_s ? req1_b   : req0_b;
                  alu_sel_r <= grant_s ? req1_sel : req0_sel;
                  id_r      <= grant_s;
                  busy_r    <= 1'b1;
                  state_r   <= ST_EXEC;
               end else begin
                  state_r   <= ST_IDLE;
               end
            end
            ST_EXEC: begin
               // The ALU has had a full cycle to settle on the registered operands.
               rsp_result_r <= alu_result;
               rsp_carry_r  <= alu_carry;
               rsp_id_r     <= id_r;
               rsp_valid_r  <= 1'b1;
               state_r      <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  // The result, carry and ID fields keep their values after the handshake.
                  rsp_valid_r <= 1'b0;
                  last_r      <= rsp_id_r;
                  busy_r      <= 1'b0;
                  state_r     <= ST_IDLE;
               end else begin
                  state_r     <= ST_RESP;
               end
            end
            default: begin
               rsp_valid_r <= 1'b0;
               busy_r      <= 1'b0;
               state_r     <= ST_IDLE;
            end
         endcase
      end
   end

   assign req0_ready = req0_ready_s;
   assign req1_ready = req1_ready_s;
   assign rsp_valid  = rsp_valid_r;
   assign rsp_id     = rsp_id_r;
   assign rsp_result = rsp_result_r;
   assign rsp_carry  = rsp_carry_r;
   assign alu_a      = alu_a_r;
   assign alu_b      = alu_b_r;
   assign alu_sel    = alu_sel_r;
   assign busy       = busy_r;

endmodule
